tsu_queue: RTL and testbench

TSU_QUEUE -- requirements
Module: tsu_queue

---
 rtl/tsu_queue.sv | 142 ++++++++++++++
 tb/tb_tsu_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tsu_queue.sv
// GMII PTP frame sniffer: timestamps each frame at the SFD and queues {ts, messageType, sequenceId} for PTP frames.
// An entry is written on the cycle gmii_ctrl drops; a full queue drops new entries unless a pop happens in the same cycle.
module tsu_queue #(
  parameter int QDEPTH = 16
) (
  input  logic        gmii_clk,
  input  logic        rst,
  input  logic        gmii_ctrl,
  input  logic [7:0]  gmii_data,
  input  logic [31:0] rtc_timer_in,
  input  logic        q_rd_en,
  output logic [7:0]  q_rd_stat,
  output logic [55:0] q_rd_data
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_BODY, S_DROP} state_t;

  state_t       r_state, w_next;
  logic [6:0]   r_cnt;
  logic [31:0]  r_ts;
  logic [7:0]   r_hold;
  logic         r_is_l2, r_udp_ok, r_seq_done;
  logic [3:0]   r_mt;
  logic [15:0]  r_seq;
  logic         w_sfd, w_byte, w_wr, w_pop, w_full, w_push;
  logic [55:0]  w_entry;

  logic [55:0]   r_mem [QDEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic [55:0]   r_rd_data;

  always_ff @(posedge gmii_clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (gmii_ctrl) w_next = (gmii_data == 8'h55) ? S_PREAMBLE : S_DROP;
      S_PREAMBLE: begin
        if (!gmii_ctrl)                w_next = S_IDLE;
        else if (gmii_data == 8'hD5)   w_next = S_BODY;
        else if (gmii_data != 8'h55)   w_next = S_DROP;
      end
      S_BODY:     if (!gmii_ctrl) w_next = S_IDLE;
      S_DROP:     if (!gmii_ctrl) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  assign w_sfd  = (r_state == S_PREAMBLE) && gmii_ctrl && (gmii_data == 8'hD5);
  assign w_byte = (r_state == S_BODY) && gmii_ctrl;
  assign w_wr   = (r_state == S_BODY) && !gmii_ctrl && r_seq_done;

  // r_hold keeps the first byte of a 16-bit field until its second byte arrives
  always_ff @(posedge gmii_clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_ts       <= '0;
      r_hold     <= '0;
      r_is_l2    <= 1'b0;
      r_udp_ok   <= 1'b0;
      r_seq_done <= 1'b0;
      r_mt       <= '0;
      r_seq      <= '0;
    end else if (w_sfd) begin
      r_ts       <= rtc_timer_in;
      r_cnt      <= '0;
      r_is_l2    <= 1'b0;
      r_udp_ok   <= 1'b0;
      r_seq_done <= 1'b0;
    end else if (w_byte) begin
      if (r_cnt != 7'd127) r_cnt <= r_cnt + 7'd1;
      case (r_cnt)
        7'd12: r_hold <= gmii_data;
        7'd13: begin
          r_is_l2  <= ({r_hold, gmii_data} == 16'h88F7);
          r_udp_ok <= ({r_hold, gmii_data} == 16'h0800);
        end
        7'd14: begin
          if (r_is_l2) r_mt <= gmii_data[3:0];
          r_udp_ok <= r_udp_ok && (gmii_data == 8'h45);
        end
        7'd23: r_udp_ok <= r_udp_ok && (gmii_data == 8'h11);
        7'd36: r_hold <= gmii_data;
        7'd37: r_udp_ok <= r_udp_ok &&
                           (({r_hold, gmii_data} == 16'd319) || ({r_hold, gmii_data} == 16'd320));
        7'd42: if (r_udp_ok) r_mt <= gmii_data[3:0];
        7'd44: if (r_is_l2) r_seq[15:8] <= gmii_data;
        7'd45: if (r_is_l2) begin
          r_seq[7:0] <= gmii_data;
          r_seq_done <= 1'b1;
        end
        7'd72: if (r_udp_ok) r_seq[15:8] <= gmii_data;
        7'd73: if (r_udp_ok) begin
          r_seq[7:0] <= gmii_data;
          r_seq_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_entry = {r_ts, 4'h0, r_mt, r_seq};
  assign w_pop   = q_rd_en && (r_count != '0);
  assign w_full  = (r_count == CW'(QDEPTH));
  // a pop in the same cycle frees the slot the write needs
  assign w_push  = w_wr && (!w_full || w_pop);

  always_ff @(posedge gmii_clk) begin
    if (w_push) r_mem[r_wp] <= w_entry;
  end

  always_ff @(posedge gmii_clk or negedge rst) begin
    if (!rst) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) begin
        r_rp      <= r_rp + AW'(1);
        r_rd_data <= r_mem[r_rp];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  assign q_rd_stat = 8'(r_count);
  assign q_rd_data = r_rd_data;

endmodule

// File: tb/tb_tsu_queue.sv
// Directed bench for tsu_queue: a frame table plus hand sequences for fill/overflow, empty pop,
// simultaneous write/pop and reset in mid-frame.
module tb_tsu_queue;

  localparam int K_L2 = 0, K_UDP319 = 1, K_UDP320 = 2, K_UDP321 = 3, K_ARP = 4, K_TCP = 5;

  logic        gmii_clk = 1'b0;
  logic        rst = 1'b1;
  logic        gmii_ctrl = 1'b0;
  logic [7:0]  gmii_data = 8'h00;
  logic [31:0] rtc_timer_in = 32'h0;
  logic        q_rd_en = 1'b0;
  logic [7:0]  q_rd_stat;
  logic [55:0] q_rd_data;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] fb [0:79];

  typedef struct {
    int          kind;
    logic [3:0]  tsn;
    logic [3:0]  mt;
    logic [15:0] seq;
    logic [31:0] ts;
    int          len;
    bit          pop_it;
    logic [7:0]  exp_stat;
    logic [55:0] exp_data;
  } vec_t;

  vec_t vt [11];

  always #5 gmii_clk = ~gmii_clk;

  tsu_queue #(.QDEPTH(16)) dut (
    .gmii_clk     (gmii_clk),
    .rst          (rst),
    .gmii_ctrl    (gmii_ctrl),
    .gmii_data    (gmii_data),
    .rtc_timer_in (rtc_timer_in),
    .q_rd_en      (q_rd_en),
    .q_rd_stat    (q_rd_stat),
    .q_rd_data    (q_rd_data)
  );

  task automatic chk(input string nm, input logic [55:0] act, input logic [55:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge gmii_clk);
    #1;
  endtask

  function automatic void build(input int kind, input logic [3:0] tsn, input logic [3:0] mt,
                                input logic [15:0] seq);
    for (int i = 0; i < 80; i++) fb[i] = 8'h20 + 8'(i % 32);
    case (kind)
      K_L2: begin
        fb[12] = 8'h88; fb[13] = 8'hF7; fb[14] = {tsn, mt};
        fb[44] = seq[15:8]; fb[45] = seq[7:0];
      end
      K_ARP: begin
        fb[12] = 8'h08; fb[13] = 8'h06; fb[14] = {tsn, mt};
        fb[44] = seq[15:8]; fb[45] = seq[7:0];
      end
      default: begin
        fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45;
        fb[23] = (kind == K_TCP) ? 8'h06 : 8'h11;
        fb[36] = 8'h01;
        fb[37] = (kind == K_UDP320) ? 8'h40 : (kind == K_UDP321) ? 8'h41 : 8'h3F;
        fb[42] = {tsn, mt};
        fb[72] = seq[15:8]; fb[73] = seq[7:0];
      end
    endcase
  endfunction

  task automatic send_pre(input logic [31:0] ts);
    gmii_ctrl = 1'b1;
    for (int i = 0; i < 7; i++) begin
      gmii_data = 8'h55; rtc_timer_in = ts ^ 32'h5A5A5A5A; tick();
    end
    gmii_data = 8'hD5; rtc_timer_in = ts; tick();
    rtc_timer_in = ~ts;
  endtask

  task automatic send_frame(input int len, input logic [31:0] ts, input bit pop_end);
    send_pre(ts);
    for (int i = 0; i < len; i++) begin
      gmii_data = fb[i]; tick();
    end
    gmii_ctrl = 1'b0; gmii_data = 8'h00; q_rd_en = pop_end; tick();
    q_rd_en = 1'b0;
  endtask

  task automatic do_pop();
    q_rd_en = 1'b1; tick(); q_rd_en = 1'b0;
  endtask

  initial begin
    vt[0]  = '{K_L2,     4'h0, 4'h0, 16'h1234, 32'h10000001, 60, 1'b1, 8'd1, 56'h10000001_00_1234};
    vt[1]  = '{K_UDP319, 4'h0, 4'h1, 16'h0007, 32'hA5A50002, 80, 1'b0, 8'd1, 56'h10000001_00_1234};
    vt[2]  = '{K_ARP,    4'h0, 4'h1, 16'h0099, 32'h00000003, 60, 1'b1, 8'd1, 56'hA5A50002_01_0007};
    vt[3]  = '{K_L2,     4'h0, 4'h0, 16'h5555, 32'h00000004, 31, 1'b0, 8'd0, 56'hA5A50002_01_0007};
    vt[4]  = '{K_UDP320, 4'h0, 4'h3, 16'hBEEF, 32'h0000ABCD, 80, 1'b1, 8'd1, 56'h0000ABCD_03_BEEF};
    vt[5]  = '{K_UDP321, 4'h0, 4'h1, 16'h0042, 32'h00000005, 80, 1'b0, 8'd0, 56'h0000ABCD_03_BEEF};
    vt[6]  = '{K_L2,     4'h1, 4'hB, 16'hFFFF, 32'hFFFFFFFF, 60, 1'b1, 8'd1, 56'hFFFFFFFF_0B_FFFF};
    vt[7]  = '{K_UDP319, 4'h0, 4'h1, 16'h0101, 32'h00000006, 73, 1'b0, 8'd0, 56'hFFFFFFFF_0B_FFFF};
    vt[8]  = '{K_TCP,    4'h0, 4'h1, 16'h0202, 32'h00000007, 80, 1'b0, 8'd0, 56'hFFFFFFFF_0B_FFFF};
    vt[9]  = '{K_L2,     4'h0, 4'h2, 16'h0A0B, 32'h12345678, 46, 1'b1, 8'd1, 56'h12345678_02_0A0B};
    vt[10] = '{K_UDP319, 4'h0, 4'h9, 16'h1357, 32'h0BADF00D, 74, 1'b1, 8'd1, 56'h0BADF00D_09_1357};

    #1 rst = 1'b0;
    #2;
    chk("reset stat", 56'(q_rd_stat), 56'd0);
    chk("reset data", q_rd_data, 56'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    for (int k = 0; k < 11; k++) begin
      build(vt[k].kind, vt[k].tsn, vt[k].mt, vt[k].seq);
      send_frame(vt[k].len, vt[k].ts, 1'b0);
      chk($sformatf("row%0d stat", k), 56'(q_rd_stat), 56'(vt[k].exp_stat));
      if (vt[k].pop_it) begin
        do_pop();
        chk($sformatf("row%0d pop data", k), q_rd_data, vt[k].exp_data);
        chk($sformatf("row%0d stat after pop", k), 56'(q_rd_stat), 56'(vt[k].exp_stat - 8'd1));
      end else begin
        chk($sformatf("row%0d held data", k), q_rd_data, vt[k].exp_data);
      end
    end

    // fill to depth, 17th frame must be dropped
    for (int i = 1; i <= 17; i++) begin
      build(K_L2, 4'h0, 4'h0, 16'(i));
      send_frame(60, 32'h100 + 32'(i), 1'b0);
      if (i >= 16) chk($sformatf("fill stat after %0d", i), 56'(q_rd_stat), 56'd16);
    end
    for (int i = 1; i <= 16; i++) begin
      do_pop();
      chk($sformatf("drain %0d", i), q_rd_data, {32'h100 + 32'(i), 8'h00, 16'(i)});
    end
    chk("drain stat", 56'(q_rd_stat), 56'd0);

    do_pop();
    chk("empty pop data", q_rd_data, {32'h110, 8'h00, 16'h0010});
    chk("empty pop stat", 56'(q_rd_stat), 56'd0);

    // write with pop at count 0, then at count 1
    build(K_L2, 4'h0, 4'h0, 16'h0AAA);
    send_frame(60, 32'h2000, 1'b1);
    chk("wr+pop empty stat", 56'(q_rd_stat), 56'd1);
    chk("wr+pop empty data", q_rd_data, {32'h110, 8'h00, 16'h0010});
    build(K_L2, 4'h0, 4'h0, 16'h0BBB);
    send_frame(60, 32'h2001, 1'b1);
    chk("wr+pop one stat", 56'(q_rd_stat), 56'd1);
    chk("wr+pop one data", q_rd_data, {32'h2000, 8'h00, 16'h0AAA});
    do_pop();
    chk("wr+pop one next", q_rd_data, {32'h2001, 8'h00, 16'h0BBB});

    // write with pop while full is accepted
    for (int i = 0; i < 16; i++) begin
      build(K_L2, 4'h0, 4'h0, 16'h300 + 16'(i));
      send_frame(60, 32'h3000 + 32'(i), 1'b0);
    end
    chk("full stat", 56'(q_rd_stat), 56'd16);
    build(K_L2, 4'h0, 4'h0, 16'h03FF);
    send_frame(60, 32'h3FFF, 1'b1);
    chk("wr+pop full stat", 56'(q_rd_stat), 56'd16);
    chk("wr+pop full data", q_rd_data, {32'h3000, 8'h00, 16'h0300});
    for (int i = 1; i < 16; i++) begin
      do_pop();
      chk($sformatf("full drain %0d", i), q_rd_data, {32'h3000 + 32'(i), 8'h00, 16'h300 + 16'(i)});
    end
    do_pop();
    chk("full drain last", q_rd_data, {32'h3FFF, 8'h00, 16'h03FF});
    chk("full drain stat", 56'(q_rd_stat), 56'd0);

    // reset in mid-frame with one entry queued
    build(K_L2, 4'h0, 4'h0, 16'h6666);
    send_frame(60, 32'h6000, 1'b0);
    build(K_L2, 4'h0, 4'h0, 16'h7777);
    send_pre(32'h6001);
    for (int i = 0; i < 20; i++) begin
      gmii_data = fb[i]; tick();
    end
    #2 rst = 1'b0;
    #1;
    chk("midframe reset stat", 56'(q_rd_stat), 56'd0);
    chk("midframe reset data", q_rd_data, 56'd0);
    gmii_data = fb[20]; tick();
    rst = 1'b1;
    for (int i = 21; i < 60; i++) begin
      gmii_data = fb[i]; tick();
    end
    gmii_ctrl = 1'b0; gmii_data = 8'h00; tick();
    chk("after reset frame stat", 56'(q_rd_stat), 56'd0);
    build(K_L2, 4'h0, 4'h0, 16'h7778);
    send_frame(60, 32'h7000, 1'b0);
    chk("recovery stat", 56'(q_rd_stat), 56'd1);
    do_pop();
    chk("recovery data", q_rd_data, {32'h7000, 8'h00, 16'h7778});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
